// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared types for the control pipeline: result-select and forward-select
// encodings, the per-stage control bundles carried through ID/EX, EX/MEM and
// MEM/WB, and a NOP constant for each bundle.
// No ports; imported with "import ctrl_pkg::*;".
package ctrl_pkg;

    // Field widths of the stage bundles. Module parameters ALUCTRL_W / REG_AW
    // default to these and must be kept equal to them.
    localparam int CTRL_ALU_W = 3;
    localparam int CTRL_REG_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultsrc_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // ID/EX register contents: everything EX needs plus what rides on to MEM/WB.
    typedef struct packed {
        logic                  reg_write;
        resultsrc_e            result_src;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src_a;
        logic [1:0]            alu_src_b;
        logic [CTRL_ALU_W-1:0] alu_control;
        logic [CTRL_REG_W-1:0] rs1;
        logic [CTRL_REG_W-1:0] rs2;
        logic [CTRL_REG_W-1:0] rd;
    } ctrl_ex_t;

    typedef struct packed {
        logic                  reg_write;
        resultsrc_e            result_src;
        logic                  mem_write;
        logic [CTRL_REG_W-1:0] rd;
    } ctrl_mem_t;

    typedef struct packed {
        logic                  reg_write;
        resultsrc_e            result_src;
        logic [CTRL_REG_W-1:0] rd;
    } ctrl_wb_t;

    localparam ctrl_ex_t  CTRL_EX_NOP  = '0;
    localparam ctrl_mem_t CTRL_MEM_NOP = '0;
    localparam ctrl_wb_t  CTRL_WB_NOP  = '0;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit
// Purely combinational stall / flush / forward-select generation.
// Build option: CTRL_PIPE_FORWARD_EN
//   defined   - RAW operands are forwarded from MEM/WB; only a load followed by
//               a consumer stalls (one cycle).
//   undefined - no forwarding; a consumer in ID stalls while its producer sits
//               in EX or MEM (up to two cycles). WB needs no stall because the
//               register file writes in the first half-cycle.
// Ports:
//   rs1_d, rs2_d          source registers of the instruction in ID
//   rs1_e, rs2_e, rd_e    registers of the instruction in EX
//   reg_write_e, result_src_e   EX write enable / result select
//   rd_m, reg_write_m     MEM destination / write enable
//   rd_w, reg_write_w     WB destination / write enable
//   pc_src_e              branch/jump redirect taken in EX
//   stall_f, stall_d      hold PC / IF-ID
//   flush_d, flush_e      clear IF-ID / load NOP into ID-EX
//   forward_a_e, forward_b_e    EX operand source selects
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = CTRL_REG_W
) (
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  resultsrc_e        result_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output fwd_e              forward_a_e,
    output fwd_e              forward_b_e
);

    logic stall;

`ifdef CTRL_PIPE_FORWARD_EN
    // MEM is younger than WB, so its value wins when both match.
    always_comb begin
        forward_a_e = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
            forward_a_e = FWD_MEM;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
            forward_a_e = FWD_WB;

        forward_b_e = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
            forward_b_e = FWD_MEM;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
            forward_b_e = FWD_WB;
    end

    // rs2 is compared even for I-type; the occasional spurious stall is accepted.
    assign stall = (result_src_e == RES_MEM) && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));

    logic fwd_inputs_unused;
    assign fwd_inputs_unused = reg_write_e;
`else
    logic raw_rs1;
    logic raw_rs2;

    // A nonzero source can never match x0, so rd != 0 is implied.
    assign raw_rs1 = (rs1_d != '0) &&
                     ((reg_write_e && (rd_e == rs1_d)) || (reg_write_m && (rd_m == rs1_d)));
    assign raw_rs2 = (rs2_d != '0) &&
                     ((reg_write_e && (rd_e == rs2_d)) || (reg_write_m && (rd_m == rs2_d)));
    assign stall   = raw_rs1 || raw_rs2;

    assign forward_a_e = FWD_RF;
    assign forward_b_e = FWD_RF;

    logic fwd_inputs_unused;
    assign fwd_inputs_unused = ^{rs1_e, rs2_e, rd_w, reg_write_w, result_src_e};
`endif

    // Stall and redirect never need arbitration: EX holds either a load or a
    // branch/jump, never both.
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_d = pc_src_e;
    assign flush_e = stall || pc_src_e;

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Carries decoded ID-stage controls through ID/EX, EX/MEM and MEM/WB, resolves
// the branch/jump redirect in EX, and hosts the hazard unit.
// Build option: CTRL_PIPE_FORWARD_EN (see hazard_unit) selects forwarding vs
// stall-only RAW handling.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   *D_i                         decoded controls / registers of the ID instruction
//   zeroE_i                      branch condition from the EX ALU
//   ALUSrcAE_o, ALUSrcBE_o, ALUControlE_o   EX ALU controls
//   pcSrcE_o                     take branch/jump target
//   forwardAE_o, forwardBE_o     EX operand selects (00 RF, 01 WB, 10 MEM)
//   memWriteM_o                  MEM store enable
//   regWriteW_o, resultSrcW_o, rdW_o   WB write-back controls
//   stallF_o, stallD_o, flushD_o front-end hold / clear
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = CTRL_ALU_W,
    parameter int REG_AW    = CTRL_REG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 regWriteD_i,
    input  logic [1:0]           resultSrcD_i,
    input  logic                 memWriteD_i,
    input  logic                 branchD_i,
    input  logic                 jumpD_i,
    input  logic                 ALUSrcAD_i,
    input  logic [1:0]           ALUSrcBD_i,
    input  logic [ALUCTRL_W-1:0] ALUControlD_i,
    input  logic [REG_AW-1:0]    rs1D_i,
    input  logic [REG_AW-1:0]    rs2D_i,
    input  logic [REG_AW-1:0]    rdD_i,
    input  logic                 zeroE_i,
    output logic                 ALUSrcAE_o,
    output logic [1:0]           ALUSrcBE_o,
    output logic [ALUCTRL_W-1:0] ALUControlE_o,
    output logic                 pcSrcE_o,
    output logic [1:0]           forwardAE_o,
    output logic [1:0]           forwardBE_o,
    output logic                 memWriteM_o,
    output logic                 regWriteW_o,
    output logic [1:0]           resultSrcW_o,
    output logic [REG_AW-1:0]    rdW_o,
    output logic                 stallF_o,
    output logic                 stallD_o,
    output logic                 flushD_o
);

    ctrl_ex_t  ctrl_d;
    ctrl_ex_t  ex_q;
    ctrl_mem_t mem_q;
    ctrl_wb_t  wb_q;
    logic      flush_e;
    fwd_e      fwd_a;
    fwd_e      fwd_b;

    always_comb begin
        ctrl_d             = CTRL_EX_NOP;
        ctrl_d.reg_write   = regWriteD_i;
        ctrl_d.result_src  = resultsrc_e'(resultSrcD_i);
        ctrl_d.mem_write   = memWriteD_i;
        ctrl_d.branch      = branchD_i;
        ctrl_d.jump        = jumpD_i;
        ctrl_d.alu_src_a   = ALUSrcAD_i;
        ctrl_d.alu_src_b   = ALUSrcBD_i;
        ctrl_d.alu_control = ALUControlD_i;
        ctrl_d.rs1         = rs1D_i;
        ctrl_d.rs2         = rs2D_i;
        ctrl_d.rd          = rdD_i;
    end

    // E/M/W never stall; only ID/EX can be replaced by a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= CTRL_EX_NOP;
            mem_q <= CTRL_MEM_NOP;
            wb_q  <= CTRL_WB_NOP;
        end else begin
            ex_q            <= flush_e ? CTRL_EX_NOP : ctrl_d;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.result_src <= ex_q.result_src;
            mem_q.mem_write <= ex_q.mem_write;
            mem_q.rd        <= ex_q.rd;
            wb_q.reg_write  <= mem_q.reg_write;
            wb_q.result_src <= mem_q.result_src;
            wb_q.rd         <= mem_q.rd;
        end
    end

    assign pcSrcE_o = (ex_q.branch && zeroE_i) || ex_q.jump;

    hazard_unit #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .rs1_d        (rs1D_i),
        .rs2_d        (rs2D_i),
        .rs1_e        (ex_q.rs1),
        .rs2_e        (ex_q.rs2),
        .rd_e         (ex_q.rd),
        .reg_write_e  (ex_q.reg_write),
        .result_src_e (ex_q.result_src),
        .rd_m         (mem_q.rd),
        .reg_write_m  (mem_q.reg_write),
        .rd_w         (wb_q.rd),
        .reg_write_w  (wb_q.reg_write),
        .pc_src_e     (pcSrcE_o),
        .stall_f      (stallF_o),
        .stall_d      (stallD_o),
        .flush_d      (flushD_o),
        .flush_e      (flush_e),
        .forward_a_e  (fwd_a),
        .forward_b_e  (fwd_b)
    );

    assign forwardAE_o   = fwd_a;
    assign forwardBE_o   = fwd_b;
    assign ALUSrcAE_o    = ex_q.alu_src_a;
    assign ALUSrcBE_o    = ex_q.alu_src_b;
    assign ALUControlE_o = ex_q.alu_control;
    assign memWriteM_o   = mem_q.mem_write;
    assign regWriteW_o   = wb_q.reg_write;
    assign resultSrcW_o  = wb_q.result_src;
    assign rdW_o         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline
// Directed scenarios followed by random instruction streams. The reference
// model keeps the last three instructions that entered EX as plain records
// and derives every expected output from them and the instruction in ID.
module tb_ctrl_pipeline;

    typedef struct {
        logic       rw;
        logic [1:0] rsrc;
        logic       mw;
        logic       br;
        logic       jp;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] alu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       regWriteD, memWriteD, branchD, jumpD, ALUSrcAD, zeroE;
    logic [1:0] resultSrcD, ALUSrcBD;
    logic [2:0] ALUControlD;
    logic [4:0] rs1D, rs2D, rdD;
    logic       ALUSrcAE, pcSrcE, memWriteM, regWriteW, stallF, stallD, flushD;
    logic [1:0] ALUSrcBE, forwardAE, forwardBE, resultSrcW;
    logic [2:0] ALUControlE;
    logic [4:0] rdW;

    ctrl_pipeline dut (
        .clk_i(clk), .rst_i(rst),
        .regWriteD_i(regWriteD), .resultSrcD_i(resultSrcD), .memWriteD_i(memWriteD),
        .branchD_i(branchD), .jumpD_i(jumpD), .ALUSrcAD_i(ALUSrcAD), .ALUSrcBD_i(ALUSrcBD),
        .ALUControlD_i(ALUControlD), .rs1D_i(rs1D), .rs2D_i(rs2D), .rdD_i(rdD),
        .zeroE_i(zeroE),
        .ALUSrcAE_o(ALUSrcAE), .ALUSrcBE_o(ALUSrcBE), .ALUControlE_o(ALUControlE),
        .pcSrcE_o(pcSrcE), .forwardAE_o(forwardAE), .forwardBE_o(forwardBE),
        .memWriteM_o(memWriteM), .regWriteW_o(regWriteW), .resultSrcW_o(resultSrcW),
        .rdW_o(rdW), .stallF_o(stallF), .stallD_o(stallD), .flushD_o(flushD)
    );

`ifdef CTRL_PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Instructions that entered EX, oldest first (at most three kept).
    instr_t hist[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t nop();
        instr_t n;
        n = '{default: '0};
        return n;
    endfunction

    // kind: 0 nop, 1 R-type, 2 I-alu, 3 lw, 4 sw, 5 beq, 6 jal
    function automatic instr_t mk(input int kind, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] alu);
        instr_t n;
        n = nop();
        case (kind)
            1: begin n.rw = 1; n.alu = alu; n.rd = rd; n.rs1 = rs1; n.rs2 = rs2; end
            2: begin n.rw = 1; n.asb = 2'b01; n.alu = alu; n.rd = rd; n.rs1 = rs1; n.rs2 = rs2; end
            3: begin n.rw = 1; n.rsrc = 2'b01; n.asb = 2'b01; n.rd = rd; n.rs1 = rs1; n.rs2 = rs2; end
            4: begin n.mw = 1; n.asb = 2'b01; n.rs1 = rs1; n.rs2 = rs2; end
            5: begin n.br = 1; n.alu = 3'b001; n.rs1 = rs1; n.rs2 = rs2; end
            6: begin n.jp = 1; n.rw = 1; n.rsrc = 2'b10; n.asa = 1; n.asb = 2'b10; n.rd = rd; end
            default: ;
        endcase
        return n;
    endfunction

    function automatic instr_t stage(input int k);
        if (hist.size() >= k) return hist[hist.size() - k];
        return nop();
    endfunction

    // MEM result is the younger one, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input instr_t m, input instr_t w);
        if (m.rw && m.rd != 0 && m.rd == rs) return 2'b10;
        if (w.rw && w.rd != 0 && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic raw_hit(input logic [4:0] rs, input instr_t e, input instr_t m);
        return rs != 0 && ((e.rw && e.rd == rs) || (m.rw && m.rd == rs));
    endfunction

    task automatic drive(input instr_t d, input logic z);
        regWriteD = d.rw; resultSrcD = d.rsrc; memWriteD = d.mw; branchD = d.br;
        jumpD = d.jp; ALUSrcAD = d.asa; ALUSrcBD = d.asb; ALUControlD = d.alu;
        rs1D = d.rs1; rs2D = d.rs2; rdD = d.rd; zeroE = z;
    endtask

    // One clock: drive ID, compare all outputs mid-cycle, advance the model.
    task automatic step(input instr_t d, input logic z, output logic st, output logic pc);
        instr_t e, m, w;
        logic [1:0] fa, fb;
        drive(d, z);
        @(negedge clk);
        e = stage(1); m = stage(2); w = stage(3);
        pc = (e.br && z) || e.jp;
        if (FWD) begin
            st = e.rsrc == 2'b01 && e.rd != 0 && (e.rd == d.rs1 || e.rd == d.rs2);
            fa = fwd_sel(e.rs1, m, w);
            fb = fwd_sel(e.rs2, m, w);
        end else begin
            st = raw_hit(d.rs1, e, m) || raw_hit(d.rs2, e, m);
            fa = 2'b00;
            fb = 2'b00;
        end
        chk("alu_src_a_e", 8'(ALUSrcAE), 8'(e.asa));
        chk("alu_src_b_e", 8'(ALUSrcBE), 8'(e.asb));
        chk("alu_ctrl_e", 8'(ALUControlE), 8'(e.alu));
        chk("pc_src_e", 8'(pcSrcE), 8'(pc));
        chk("forward_a", 8'(forwardAE), 8'(fa));
        chk("forward_b", 8'(forwardBE), 8'(fb));
        chk("mem_write_m", 8'(memWriteM), 8'(m.mw));
        chk("reg_write_w", 8'(regWriteW), 8'(w.rw));
        chk("result_src_w", 8'(resultSrcW), 8'(w.rsrc));
        chk("rd_w", 8'(rdW), 8'(w.rd));
        chk("stall_f", 8'(stallF), 8'(st));
        chk("stall_d", 8'(stallD), 8'(st));
        chk("flush_d", 8'(flushD), 8'(pc));
        @(posedge clk);
        hist.push_back((st || pc) ? nop() : d);
        if (hist.size() > 3) void'(hist.pop_front());
        #1;
    endtask

    // Present an instruction in ID until it is accepted into EX.
    task automatic issue(input instr_t d, input logic z, output int nst);
        logic st, pc;
        nst = 0;
        for (int i = 0; i < 4; i++) begin
            step(d, z, st, pc);
            if (!st) return;
            nst++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL stall_bound stalls=%0d required<=2", nst);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_alu_src_a_e"}, 8'(ALUSrcAE), 8'd0);
        chk({pfx, "_alu_src_b_e"}, 8'(ALUSrcBE), 8'd0);
        chk({pfx, "_alu_ctrl_e"}, 8'(ALUControlE), 8'd0);
        chk({pfx, "_pc_src_e"}, 8'(pcSrcE), 8'd0);
        chk({pfx, "_forward_a"}, 8'(forwardAE), 8'd0);
        chk({pfx, "_forward_b"}, 8'(forwardBE), 8'd0);
        chk({pfx, "_mem_write_m"}, 8'(memWriteM), 8'd0);
        chk({pfx, "_reg_write_w"}, 8'(regWriteW), 8'd0);
        chk({pfx, "_result_src_w"}, 8'(resultSrcW), 8'd0);
        chk({pfx, "_rd_w"}, 8'(rdW), 8'd0);
        chk({pfx, "_stall_f"}, 8'(stallF), 8'd0);
        chk({pfx, "_stall_d"}, 8'(stallD), 8'd0);
        chk({pfx, "_flush_d"}, 8'(flushD), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        logic st, pc, keep;
        instr_t d;

        // power-on reset
        drive(nop(), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        rst = 1'b0;

        // R-type add x5 reaches EX after 1 cycle and WB after 3
        issue(mk(1, 5, 1, 2, 3'b000), 1'b0, ns);
        chk("t2_alu_ctrl_e", 8'(ALUControlE), 8'd0);
        chk("t2_reg_write_e1", 8'(regWriteW), 8'd0);
        step(nop(), 1'b0, st, pc);
        step(nop(), 1'b0, st, pc);
        chk("t2_reg_write_w", 8'(regWriteW), 8'd1);
        chk("t2_rd_w", 8'(rdW), 8'd5);

        // load-use: lw x6 then add x7,x6,x1
        issue(mk(3, 6, 1, 0, 3'b000), 1'b0, ns);
        issue(mk(1, 7, 6, 1, 3'b000), 1'b0, ns);
        chk("t3_stalls", 8'(ns), FWD ? 8'd1 : 8'd2);
        chk("t3_forward_a", 8'(forwardAE), FWD ? 8'd1 : 8'd0);
        step(nop(), 1'b0, st, pc);

        // RAW ALU: add x3 then sub x4,x3,x3
        issue(mk(1, 3, 1, 2, 3'b000), 1'b0, ns);
        issue(mk(1, 4, 3, 3, 3'b001), 1'b0, ns);
        chk("t4_stalls", 8'(ns), FWD ? 8'd0 : 8'd2);
        chk("t4_forward_a", 8'(forwardAE), FWD ? 8'd2 : 8'd0);
        chk("t4_forward_b", 8'(forwardBE), FWD ? 8'd2 : 8'd0);

        // taken beq flushes and leaves a NOP in EX
        issue(mk(5, 0, 1, 2, 3'b000), 1'b0, ns);
        step(mk(1, 8, 1, 2, 3'b011), 1'b1, st, pc);
        chk("t5_beq_pc", 8'(pc), 8'd1);
        chk("t5_beq_alu_e", 8'(ALUControlE), 8'd0);
        chk("t5_beq_pc_after", 8'(pcSrcE), 8'd0);
        // jal redirects regardless of zero
        issue(mk(6, 1, 0, 0, 3'b000), 1'b0, ns);
        step(mk(1, 8, 1, 2, 3'b011), 1'b0, st, pc);
        chk("t5_jal_pc", 8'(pc), 8'd1);
        chk("t5_jal_alu_e", 8'(ALUControlE), 8'd0);
        // not-taken beq lets the next instruction into EX
        issue(mk(5, 0, 1, 2, 3'b000), 1'b0, ns);
        step(mk(1, 9, 2, 2, 3'b011), 1'b0, st, pc);
        chk("t5_nt_pc", 8'(pc), 8'd0);
        chk("t5_nt_alu_e", 8'(ALUControlE), 8'd3);

        // x0 destination never causes a hazard
        issue(mk(3, 0, 1, 0, 3'b000), 1'b0, ns);
        issue(mk(1, 1, 0, 0, 3'b000), 1'b0, ns);
        chk("t6_stalls", 8'(ns), 8'd0);
        chk("t6_forward_a", 8'(forwardAE), 8'd0);
        chk("t6_forward_b", 8'(forwardBE), 8'd0);

        // async reset with a load in EX
        issue(mk(3, 6, 1, 0, 3'b000), 1'b0, ns);
        drive(mk(1, 7, 6, 6, 3'b000), 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        issue(mk(1, 5, 1, 2, 3'b000), 1'b0, ns);
        chk("t1_reg_write_w1", 8'(regWriteW), 8'd0);
        step(nop(), 1'b0, st, pc);
        chk("t1_reg_write_w2", 8'(regWriteW), 8'd0);
        step(nop(), 1'b0, st, pc);
        chk("t1_reg_write_w3", 8'(regWriteW), 8'd1);

        // random instruction stream; stalled instructions are held in ID,
        // a redirect replaces ID with a bubble
        keep = 1'b0;
        d = nop();
        for (int c = 0; c < 400; c++) begin
            if (!keep)
                d = mk($urandom_range(0, 6), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)));
            step(d, 1'($urandom_range(0, 1)), st, pc);
            if (pc) begin
                d = nop();
                keep = 1'b1;
            end else begin
                keep = st;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
